// File: rtl/adc_timing_pkg.sv
// rtl/adc_timing_pkg.sv - lock FSM state encoding, SVGA 800x600 timing and sync latency constants
package adc_timing_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_VERIFY = 2'd2,
    ST_LOCKED = 2'd3
  } lock_state_t;

  localparam int SVGA_H_TOTAL = 1056;
  localparam int SVGA_V_TOTAL = 628;
  localparam int SYNC_LAT     = 8;
  // Latency = 2 synchronizer flops + filter window + registered edge pulse.
  localparam int FILT_LEN     = SYNC_LAT - 3;
  localparam int CNT_W        = 11;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic line_in_tol(input logic [CNT_W-1:0] meas, input int exp_len,
                                       input int tol);
    int diff;
    diff = int'(meas) - exp_len;
    return (diff <= tol) && (diff >= -tol);
  endfunction

endpackage

// File: rtl/sync_edge_filter.sv
// rtl/sync_edge_filter.sv - 2-flop synchronizer, 5-sample glitch filter and rising-edge pulse
module sync_edge_filter
  import adc_timing_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic sync_raw,
  output logic pulse
);

  logic [1:0]          sync_q;
  logic [FILT_LEN-1:0] hist;
  logic                level;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      hist   <= '0;
      level  <= 1'b0;
      pulse  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], sync_raw};
      hist   <= {hist[FILT_LEN-2:0], sync_q[1]};
      pulse  <= 1'b0;
      if (&hist) begin
        level <= 1'b1;
        pulse <= ~level;
      end else if (~|hist) begin
        level <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/adc_sync_lock_ctrl.sv
// rtl/adc_sync_lock_ctrl.sv - ADC sync lock controller; ADC_LOCK_ERR_COUNT_EN adds lock_loss_count
module adc_sync_lock_ctrl
  import adc_timing_pkg::*;
#(
  parameter int EXP_H_TOTAL = SVGA_H_TOTAL,
  parameter int EXP_V_TOTAL = SVGA_V_TOTAL,
  parameter int H_TOL       = 2,
  parameter int LOCK_FRAMES = 4,
  parameter int LOSS_FRAMES = 2
) (
  input  logic        hw_pixel_clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        hw_hsync_in,
  input  logic        hw_vsync_in,
  output logic        locked,
  output logic        capture_enable,
  output logic [10:0] h_total,
  output logic [10:0] v_total,
  output logic [1:0]  state
`ifdef ADC_LOCK_ERR_COUNT_EN
  ,
  output logic [7:0]  lock_loss_count
`endif
);

  lock_state_t      cur, nxt;
  logic             hs_pulse, vs_pulse;
  logic [CNT_W-1:0] pix_cnt, line_cnt, lines_closing;
  logic             lines_ok, line_good, frame_good, pix_sat;
  logic [7:0]       good_cnt, good_nxt, bad_cnt, bad_nxt;

  sync_edge_filter u_hsync_filter (
    .clk(hw_pixel_clk), .reset(reset), .sync_raw(hw_hsync_in), .pulse(hs_pulse)
  );
  sync_edge_filter u_vsync_filter (
    .clk(hw_pixel_clk), .reset(reset), .sync_raw(hw_vsync_in), .pulse(vs_pulse)
  );

  // An hsync coincident with vsync belongs to the closing frame.
  assign line_good     = line_in_tol(pix_cnt, EXP_H_TOTAL, H_TOL);
  assign lines_closing = (hs_pulse && line_cnt != CNT_MAX) ? line_cnt + CNT_W'(1) : line_cnt;
  assign frame_good    = (int'(lines_closing) == EXP_V_TOTAL) && lines_ok && (!hs_pulse || line_good);
  assign pix_sat       = (pix_cnt == CNT_MAX);

  always_comb begin
    nxt      = cur;
    good_nxt = good_cnt;
    bad_nxt  = bad_cnt;
    case (cur)
      ST_IDLE: begin
        good_nxt = '0;
        bad_nxt  = '0;
        if (enable) nxt = ST_SEARCH;
      end
      ST_SEARCH: begin
        if (vs_pulse) begin
          nxt      = ST_VERIFY;
          good_nxt = '0;
          bad_nxt  = '0;
        end
      end
      ST_VERIFY: begin
        if (pix_sat) begin
          nxt = ST_SEARCH;
        end else if (vs_pulse) begin
          if (!frame_good) begin
            good_nxt = '0;
          end else if (int'(good_cnt) + 1 >= LOCK_FRAMES) begin
            nxt      = ST_LOCKED;
            good_nxt = '0;
          end else begin
            good_nxt = good_cnt + 8'd1;
          end
        end
      end
      default: begin
        if (pix_sat) begin
          nxt = ST_SEARCH;
        end else if (vs_pulse) begin
          if (frame_good) begin
            bad_nxt = '0;
          end else if (int'(bad_cnt) + 1 >= LOSS_FRAMES) begin
            nxt     = ST_SEARCH;
            bad_nxt = '0;
          end else begin
            bad_nxt = bad_cnt + 8'd1;
          end
        end
      end
    endcase
    if (!enable) nxt = ST_IDLE;
  end

  always_ff @(posedge hw_pixel_clk) begin
    if (reset) begin
      cur      <= ST_IDLE;
      good_cnt <= '0;
      bad_cnt  <= '0;
    end else begin
      cur      <= nxt;
      good_cnt <= good_nxt;
      bad_cnt  <= bad_nxt;
    end
  end

  always_ff @(posedge hw_pixel_clk) begin
    if (reset) begin
      pix_cnt        <= '0;
      line_cnt       <= '0;
      lines_ok       <= 1'b0;
      h_total        <= '0;
      v_total        <= '0;
      capture_enable <= 1'b0;
    end else begin
      capture_enable <= (nxt == ST_LOCKED) && (capture_enable || (cur == ST_LOCKED && vs_pulse));
      if (cur == ST_IDLE) begin
        pix_cnt  <= '0;
        line_cnt <= '0;
        lines_ok <= 1'b0;
      end else begin
        if (hs_pulse) begin
          pix_cnt <= CNT_W'(1);
          h_total <= pix_cnt;
        end else if (!pix_sat) begin
          pix_cnt <= pix_cnt + CNT_W'(1);
        end
        if (vs_pulse) begin
          v_total  <= lines_closing;
          line_cnt <= '0;
          lines_ok <= 1'b1;
        end else if (hs_pulse) begin
          line_cnt <= lines_closing;
          lines_ok <= lines_ok & line_good;
        end
      end
    end
  end

`ifdef ADC_LOCK_ERR_COUNT_EN
  always_ff @(posedge hw_pixel_clk) begin
    if (reset) begin
      lock_loss_count <= '0;
    end else if (cur == ST_LOCKED && nxt == ST_SEARCH && lock_loss_count != 8'hFF) begin
      lock_loss_count <= lock_loss_count + 8'd1;
    end
  end
`endif

  assign locked = (cur == ST_LOCKED);
  assign state  = cur;

endmodule

// File: doc/adc_sync_lock_ctrl.md
ADC_SYNC_LOCK_CTRL -- requirements
Module: adc_sync_lock_ctrl

Interface
REQ-001 Parameter EXP_H_TOTAL, default 1056, expected pixel clocks per line.
REQ-002 Parameter EXP_V_TOTAL, default 628, expected lines per frame.
REQ-003 Parameter H_TOL, default 2, allowed +/- deviation of a measured line length.
REQ-004 Parameter LOCK_FRAMES, default 4, consecutive good frames required to lock.
REQ-005 Parameter LOSS_FRAMES, default 2, consecutive bad frames required to drop lock.
REQ-006 Port hw_pixel_clk, input, 1 bit, the only clock; all logic on its rising edge.
REQ-007 Port reset, input, 1 bit, synchronous, active-high.
REQ-008 Port enable, input, 1 bit, arms the controller; low forces IDLE.
REQ-009 Ports hw_hsync_in and hw_vsync_in, input, 1 bit each, raw ADC sync pins, active-high.
REQ-010 Port locked, output, 1 bit, high while in LOCKED.
REQ-011 Port capture_enable, output, 1 bit, gates FIFO writes of the capture path.
REQ-012 Ports h_total and v_total, output, 11 bits each, last measured line length and line count.
REQ-013 Port state, output, 2 bits, current FSM state encoding.

Function
REQ-014 Each sync input SHALL pass a 2-flop synchronizer and a 5-sample filter: the filtered level goes high when 5 consecutive samples are 1 and low when 5 consecutive samples are 0, otherwise it holds.
REQ-015 The filtered rising edge SHALL emit a one-cycle pulse exactly 8 cycles after the first cycle of a stable-high pin.
REQ-016 The pixel counter SHALL count cycles between consecutive hsync pulses, saturate at 2047, and on each pulse latch that count into h_total and restart at 1.
REQ-017 A line is good when abs(h_total - EXP_H_TOTAL) <= H_TOL; the line check SHALL use the value being latched in the same cycle.
REQ-018 The line counter SHALL count hsync pulses since the previous vsync pulse; on a vsync pulse it SHALL latch into v_total and clear.
REQ-019 An hsync pulse coincident with a vsync pulse SHALL be counted in the closing frame and its line checked before frame evaluation.
REQ-020 A frame is good when v_total equals EXP_V_TOTAL and every line in it was good.
REQ-021 FSM states: IDLE=0, SEARCH=1, VERIFY=2, LOCKED=3.
REQ-022 IDLE->SEARCH when enable=1; any state->IDLE one cycle after enable=0.
REQ-023 SEARCH->VERIFY on the first vsync pulse, with the good-frame counter cleared.
REQ-024 In VERIFY, a good frame SHALL increment the good-frame counter; reaching LOCK_FRAMES SHALL enter LOCKED; a bad frame SHALL clear the counter and remain in VERIFY.
REQ-025 In LOCKED, a bad frame SHALL increment the bad-frame counter and a good frame SHALL clear it; reaching LOSS_FRAMES SHALL enter SEARCH.
REQ-026 Pixel counter saturation (no hsync for 2047 cycles) in VERIFY or LOCKED SHALL enter SEARCH on the next cycle.
REQ-027 capture_enable SHALL rise on the first vsync pulse after LOCKED is entered and SHALL fall in the same cycle the FSM leaves LOCKED.
REQ-028 h_total and v_total SHALL update in every state except IDLE.

Reset
REQ-029 Reset SHALL set the state to IDLE, clear all counters and filters to 0, and drive locked=0, capture_enable=0, h_total=0 and v_total=0.
REQ-030 Reset asserted mid-frame SHALL take effect in the next cycle regardless of enable, and it overrides all other transitions.

Configuration
REQ-031 With ADC_LOCK_ERR_COUNT_EN defined, an output lock_loss_count[7:0] SHALL increment, saturating at 255, on each LOCKED->SEARCH transition; reset clears it and IDLE preserves it.
REQ-032 Without ADC_LOCK_ERR_COUNT_EN, the port and its counter SHALL be absent and all other behaviour is identical.

Structure
REQ-033 Package adc_timing_pkg SHALL hold the state typedef, the SVGA 800x600 timing constants (1056/628) and SYNC_LAT=8.
REQ-034 The synchronizer, filter and edge pulse SHALL be a sub-module sync_edge_filter, instantiated once per sync input.

Verification
REQ-035 Clean 1056x628 timing with enable=1: locked rises at the 5th vsync pulse (1 in SEARCH plus 4 good frames), capture_enable rises at the 6th pulse, h_total=1056 and v_total=628.
REQ-036 A 1-cycle glitch on hsync_in and a 4-cycle pulse produce no edge pulse; a 5-cycle pulse produces a pulse 8 cycles after its start.
REQ-037 While LOCKED, one 1060-clock line gives 1 bad frame with lock held; 2 consecutive bad frames give state=SEARCH and capture_enable=0 in the same cycle.
REQ-038 Lines of 1054 and 1058 clocks count as good; a line of 1059 clocks counts as bad.
REQ-039 Stopping hsync while LOCKED gives SEARCH at the cycle after saturation at 2047 and lock_loss_count=1 when the macro is defined.
REQ-040 Reset or enable=0 asserted mid-frame while LOCKED gives state=IDLE with all outputs per REQ-029 (enable=0 keeps h_total/v_total) and no spurious lock after re-enable before 5 vsync pulses.
